packet_demux: RTL and testbench
===============================

// Module: packet_demux
// PURPOSE
//  Splits one channel-tagged AVST packet stream into NUM_PORTS per-port AVST streams; dual of packet_mux.
//  Sits on the RX path downstream of the shared MAC/DMA stream and feeds the per-channel consumers.
//  Channel is sampled on SOP and locked for the whole packet, so packets are never split across ports.
//  Each output has a 2-entry skid buffer: registered outputs, full throughput per port.
// PARAMETERS
//  NUM_PORTS        4   number of output ports (2..16)
//  AVST_DATA_WIDTH  64  data bus width; empty width = components_pkg::get_width(AVST_DATA_WIDTH)-3
//  USER_DATA_WIDTH  64  sideband user data carried with every beat
//  AVST_ERROR_WIDTH 1   error field width, passed through unchanged
//  BIT_POSITION     0   0: i_avst_channel is binary index; 1: one-hot, width NUM_PORTS
//  CNT_WIDTH        32  width of drop counters (saturating)
// PORTS
//  clk                   in   1          single clock for all logic
//  rst_n                 in   1          async assert, active-low reset; deassertion synchronised externally
//  i_avst_ready          out  1          ready latency 0
//  i_avst_valid          in   1          input beat valid
//  i_avst_startofpacket  in   1          SOP
//  i_avst_endofpacket    in   1          EOP
//  i_avst_channel        in   CH_W       destination port (CH_W = BIT_POSITION ? NUM_PORTS : get_width(NUM_PORTS))
//  i_avst_error          in   ERR_W      per-beat error
//  i_avst_empty          in   EMPTY_W    empty bytes on EOP beat
//  i_avst_data           in   DATA_W     payload
//  i_avst_user_data      in   USER_W     sideband
//  o_avst_ready[N]       in   1          per-port ready, latency 0
//  o_avst_valid[N]       out  1          per-port valid
//  o_avst_startofpacket[N], o_avst_endofpacket[N], o_avst_error[N], o_avst_empty[N],
//  o_avst_data[N], o_avst_user_data[N]   out  as input   per-port copies of input fields
//  o_drop_bad_ch_cnt     out  CNT_W      packets dropped for invalid channel
//  o_drop_no_sop_cnt     out  CNT_W      beats dropped while IDLE without SOP
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, locked port=0, skid buffers empty, all o_avst_valid=0,
//   o_avst_* data fields=0, both counters=0, i_avst_ready=0 while in reset.
//  Transfer: input beat accepted when i_avst_valid & i_avst_ready; output beat when o_valid & o_ready.
//  Latency: accepted beat appears on its port's outputs the following cycle (1 clk) if that port buffer was empty.
//  Channel decode: binary -> valid if < NUM_PORTS; one-hot -> valid iff exactly one bit set, index = that bit.
//  FSM (demux_state_e): IDLE, FWD, DROP.
//   IDLE: i_avst_ready = decoded port's skid ready if SOP & valid ch; 1 otherwise (non-SOP/bad ch drained).
//    SOP, valid ch, accepted: write beat to port, lock port; EOP same beat -> stay IDLE, else -> FWD.
//    SOP, invalid ch: beat discarded, o_drop_bad_ch_cnt+1; EOP same beat -> IDLE, else -> DROP.
//    non-SOP beat: discarded, o_drop_no_sop_cnt+1, stay IDLE.
//   FWD: i_avst_ready = locked port skid ready; i_avst_channel ignored; a further SOP is forwarded as data
//    (no re-lock); accepted EOP -> IDLE.
//   DROP: i_avst_ready=1; all beats discarded; accepted EOP -> IDLE.
//  Skid buffer: 2 entries; ready to upstream = not full (registered); accepting and emitting in same
//   cycle keeps occupancy; back-to-back beats to one port at 1 beat/clk while o_ready=1.
//  Blocking: backpressure on the locked/target port stalls the whole input (no reordering, no HOL bypass).
//  Counters saturate at all-ones; no wrap.
//  Reset mid-packet: partial packets in buffers discarded; downstream sees no EOP for them (consumer must
//   tolerate); input restarts in IDLE, so remainder of an in-flight packet counts as no-SOP drops.
//  Outputs fields other than valid are don't-care when valid=0 but must hold stable while valid & !ready.
// STRUCTURE
//  components_pkg: demux_state_e typedef {IDLE, FWD, DROP}; reuse get_width(); add onehot_to_idx function
//   returning {valid, index}.
//  Sub-module avst_skid_buffer (2-entry, parameterised payload width), one instance per port via generate;
//   payload = {sop, eop, error, empty, data, user_data}.
//  Top: decode, FSM, lock register, per-port write enables, counters. Target ~250 lines.
// TESTING
//  1. Reset, then 3-beat pkt ch=2 with all o_ready=1 -> port2 sees SOP..EOP 1 clk later, ports 0/1/3 valid=0.
//  2. Pkt to ch=1 with channel field changed to 3 on beat 2 -> all beats on port1, port3 idle.
//  3. BIT_POSITION=1, SOP ch=4'b0110 (2-beat pkt) -> both beats dropped, bad_ch_cnt=1, i_avst_ready=1 throughout.
//  4. Beat with SOP=0 while IDLE -> dropped, no_sop_cnt=1, no output valid.
//  5. Port0 o_ready=0 during 5-beat pkt -> port0 buffers 2 beats, i_avst_ready=0 from 3rd beat; release
//     -> all 5 beats delivered in order, no loss or duplication.
//  6. Assert rst_n=0 mid-packet -> all o_avst_valid=0 same cycle, counters=0; after release, next SOP pkt
//     routes correctly; counter preset to all-ones stays all-ones on further drops.

Source files
------------

// File: rtl/components_pkg.sv
// rtl/components_pkg.sv - shared types and width helpers for the AVST stream components
package components_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } demux_state_e;

  // Bits needed to index n items; never less than 1 so a 2-entry select still has a bit.
  function automatic int get_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int get_empty_width(input int data_width);
    return (get_width(data_width) > 3) ? get_width(data_width) - 3 : 1;
  endfunction

  // Returns {exactly_one_bit_set, index_of_highest_set_bit}.
  function automatic logic [4:0] onehot_to_idx(input logic [15:0] vec);
    logic [3:0] idx;
    logic [4:0] cnt;
    idx = '0;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) begin
        idx = 4'(i);
        cnt = cnt + 5'd1;
      end
    end
    return {(cnt == 5'd1), idx};
  endfunction

endpackage

// File: rtl/avst_skid_buffer.sv
// rtl/avst_skid_buffer.sv - 2-entry skid buffer with registered outputs
module avst_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_tvalid,
  output logic             in_tready,
  input  logic [WIDTH-1:0] in_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic [WIDTH-1:0] out_tdata
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             push;
  logic             pop;

  // The skid entry only fills while the output entry is stalled, so it doubles as the full flag.
  assign in_tready = ~skid_valid;
  assign push      = in_tvalid & ~skid_valid;
  assign pop       = out_tvalid & out_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_tvalid || pop) begin
      if (skid_valid) begin
        out_tvalid <= 1'b1;
        out_tdata  <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_tvalid <= push;
        if (push) out_tdata <= in_tdata;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= in_tdata;
    end
  end

endmodule

// File: rtl/packet_demux.sv
// rtl/packet_demux.sv - routes channel-tagged AVST packets to per-port skid-buffered outputs
module packet_demux
  import components_pkg::*;
#(
  parameter int NUM_PORTS        = 4,
  parameter int AVST_DATA_WIDTH  = 64,
  parameter int USER_DATA_WIDTH  = 64,
  parameter int AVST_ERROR_WIDTH = 1,
  parameter int BIT_POSITION     = 0,
  parameter int CNT_WIDTH        = 32,
  localparam int CH_W    = (BIT_POSITION != 0) ? NUM_PORTS : get_width(NUM_PORTS),
  localparam int EMPTY_W = get_empty_width(AVST_DATA_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        i_avst_ready,
  input  logic                        i_avst_valid,
  input  logic                        i_avst_startofpacket,
  input  logic                        i_avst_endofpacket,
  input  logic [CH_W-1:0]             i_avst_channel,
  input  logic [AVST_ERROR_WIDTH-1:0] i_avst_error,
  input  logic [EMPTY_W-1:0]          i_avst_empty,
  input  logic [AVST_DATA_WIDTH-1:0]  i_avst_data,
  input  logic [USER_DATA_WIDTH-1:0]  i_avst_user_data,
  input  logic [NUM_PORTS-1:0]        o_avst_ready,
  output logic [NUM_PORTS-1:0]        o_avst_valid,
  output logic [NUM_PORTS-1:0]        o_avst_startofpacket,
  output logic [NUM_PORTS-1:0]        o_avst_endofpacket,
  output logic [AVST_ERROR_WIDTH-1:0] o_avst_error     [NUM_PORTS],
  output logic [EMPTY_W-1:0]          o_avst_empty     [NUM_PORTS],
  output logic [AVST_DATA_WIDTH-1:0]  o_avst_data      [NUM_PORTS],
  output logic [USER_DATA_WIDTH-1:0]  o_avst_user_data [NUM_PORTS],
  output logic [CNT_WIDTH-1:0]        o_drop_bad_ch_cnt,
  output logic [CNT_WIDTH-1:0]        o_drop_no_sop_cnt
);

  localparam int PAY_W = 2 + AVST_ERROR_WIDTH + EMPTY_W + AVST_DATA_WIDTH + USER_DATA_WIDTH;

  demux_state_e         state;
  logic [3:0]           lock_idx;
  logic                 run;
  logic [CNT_WIDTH-1:0] bad_ch_cnt;
  logic [CNT_WIDTH-1:0] no_sop_cnt;

  logic [15:0]          ch_ext;
  logic [4:0]           oh_dec;
  logic                 ch_ok;
  logic [3:0]           ch_idx;
  logic [3:0]           tgt_idx;
  logic                 tgt_rdy;
  logic                 fwd_sel;
  logic                 accept;
  logic [NUM_PORTS-1:0] skid_rdy;
  logic [NUM_PORTS-1:0] wr_en;
  logic [PAY_W-1:0]     in_pay;

  always_comb begin
    ch_ext               = '0;
    ch_ext[CH_W-1:0]     = i_avst_channel;
    oh_dec               = onehot_to_idx(ch_ext);
    if (BIT_POSITION != 0) begin
      ch_ok  = oh_dec[4];
      ch_idx = oh_dec[3:0];
    end else begin
      ch_ok  = (ch_ext < 16'(NUM_PORTS));
      ch_idx = ch_ext[3:0];
    end
  end

  // Only a routable SOP in IDLE or any beat in FWD waits on a port; everything else is drained.
  always_comb begin
    tgt_idx = (state == FWD) ? lock_idx : ch_idx;
    tgt_rdy = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (tgt_idx == 4'(p)) tgt_rdy = skid_rdy[p];
    end
    fwd_sel      = (state == FWD) || ((state == IDLE) && i_avst_startofpacket && ch_ok);
    i_avst_ready = run && (fwd_sel ? tgt_rdy : 1'b1);
    accept       = i_avst_valid && i_avst_ready;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_en[p] = accept && fwd_sel && (tgt_idx == 4'(p));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lock_idx   <= '0;
      run        <= 1'b0;
      bad_ch_cnt <= '0;
      no_sop_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        unique case (state)
          IDLE: begin
            if (i_avst_startofpacket) begin
              if (ch_ok) begin
                lock_idx <= ch_idx;
                if (!i_avst_endofpacket) state <= FWD;
              end else begin
                if (bad_ch_cnt != '1) bad_ch_cnt <= bad_ch_cnt + CNT_WIDTH'(1);
                if (!i_avst_endofpacket) state <= DROP;
              end
            end else if (no_sop_cnt != '1) begin
              no_sop_cnt <= no_sop_cnt + CNT_WIDTH'(1);
            end
          end
          FWD, DROP: begin
            if (i_avst_endofpacket) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_drop_bad_ch_cnt = bad_ch_cnt;
  assign o_drop_no_sop_cnt = no_sop_cnt;

  assign in_pay = {i_avst_startofpacket, i_avst_endofpacket, i_avst_error,
                   i_avst_empty, i_avst_data, i_avst_user_data};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [PAY_W-1:0] out_pay;

    avst_skid_buffer #(
      .WIDTH (PAY_W)
    ) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_tvalid  (wr_en[p]),
      .in_tready  (skid_rdy[p]),
      .in_tdata   (in_pay),
      .out_tvalid (o_avst_valid[p]),
      .out_tready (o_avst_ready[p]),
      .out_tdata  (out_pay)
    );

    assign {o_avst_startofpacket[p], o_avst_endofpacket[p], o_avst_error[p],
            o_avst_empty[p], o_avst_data[p], o_avst_user_data[p]} = out_pay;
  end

endmodule

// File: tb/tb_packet_demux.sv
// tb/tb_packet_demux.sv - randomized self-checking bench for packet_demux (one-hot channel build)
module tb_packet_demux;

  localparam int NP   = 4;
  localparam int DW   = 16;
  localparam int UW   = 8;
  localparam int EW   = 1;
  localparam int MW   = 1;
  localparam int CW   = 4;
  localparam int CNTW = 4;
  localparam int PW   = 2 + EW + MW + DW + UW;
  localparam int SAT  = (1 << CNTW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_avst_ready;
  logic          i_avst_valid = 1'b0;
  logic          i_sop = 1'b0;
  logic          i_eop = 1'b0;
  logic [CW-1:0] i_ch = '0;
  logic [EW-1:0] i_err = '0;
  logic [MW-1:0] i_empty = '0;
  logic [DW-1:0] i_data = '0;
  logic [UW-1:0] i_user = '0;
  logic [NP-1:0] o_ready = '0;
  logic [NP-1:0] o_valid;
  logic [NP-1:0] o_sop;
  logic [NP-1:0] o_eop;
  logic [EW-1:0] o_err   [NP];
  logic [MW-1:0] o_empty [NP];
  logic [DW-1:0] o_data  [NP];
  logic [UW-1:0] o_user  [NP];
  logic [CNTW-1:0] bad_cnt;
  logic [CNTW-1:0] nosop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [PW-1:0] expq [NP][$];
  bit            in_pkt = 1'b0;
  bit            dropping = 1'b0;
  int            cur_port = -1;
  int            m_bad = 0;
  int            m_nosop = 0;
  bit            rand_rdy = 1'b0;
  bit            prev_stall [NP];
  logic [PW-1:0] prev_pay [NP];

  always #5 clk = ~clk;

  packet_demux #(
    .NUM_PORTS        (NP),
    .AVST_DATA_WIDTH  (DW),
    .USER_DATA_WIDTH  (UW),
    .AVST_ERROR_WIDTH (EW),
    .BIT_POSITION     (1),
    .CNT_WIDTH        (CNTW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_avst_ready         (i_avst_ready),
    .i_avst_valid         (i_avst_valid),
    .i_avst_startofpacket (i_sop),
    .i_avst_endofpacket   (i_eop),
    .i_avst_channel       (i_ch),
    .i_avst_error         (i_err),
    .i_avst_empty         (i_empty),
    .i_avst_data          (i_data),
    .i_avst_user_data     (i_user),
    .o_avst_ready         (o_ready),
    .o_avst_valid         (o_valid),
    .o_avst_startofpacket (o_sop),
    .o_avst_endofpacket   (o_eop),
    .o_avst_error         (o_err),
    .o_avst_empty         (o_empty),
    .o_avst_data          (o_data),
    .o_avst_user_data     (o_user),
    .o_drop_bad_ch_cnt    (bad_cnt),
    .o_drop_no_sop_cnt    (nosop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_port(input logic [CW-1:0] ch);
    if ($countones(ch) != 1) return -1;
    for (int i = 0; i < CW; i++) if (ch[i]) return i;
    return -1;
  endfunction

  // Reference: packets follow the channel of their SOP; everything else outside a packet is a drop.
  task automatic model_accept(input logic sop, input logic eop, input logic [CW-1:0] ch,
                              input logic [PW-1:0] pay);
    if (!in_pkt) begin
      if (sop) begin
        cur_port = oh_port(ch);
        dropping = (cur_port < 0);
        if (dropping) m_bad = (m_bad < SAT) ? m_bad + 1 : SAT;
        else expq[cur_port].push_back(pay);
        in_pkt = !eop;
      end else begin
        m_nosop = (m_nosop < SAT) ? m_nosop + 1 : SAT;
      end
    end else begin
      if (!dropping) expq[cur_port].push_back(pay);
      if (eop) in_pkt = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) expq[p].delete();
    in_pkt = 1'b0;
    dropping = 1'b0;
    cur_port = -1;
    m_bad = 0;
    m_nosop = 0;
  endtask

  task automatic send(input logic sop, input logic eop, input logic [CW-1:0] ch, output bit first);
    logic [PW-1:0] pay;
    int waited;
    @(negedge clk);
    i_avst_valid = 1'b1;
    i_sop   = sop;
    i_eop   = eop;
    i_ch    = ch;
    i_err   = EW'($urandom);
    i_empty = MW'($urandom);
    i_data  = DW'($urandom);
    i_user  = UW'($urandom);
    pay = {sop, eop, i_err, i_empty, i_data, i_user};
    waited = 0;
    #4;
    while (!i_avst_ready && waited < 200) begin
      @(negedge clk);
      #4;
      waited++;
    end
    first = (waited == 0);
    if (i_avst_ready) model_accept(sop, eop, ch, pay);
    else check("accept_timeout", 64'(i_avst_ready), 64'd1);
    @(posedge clk);
    #1 i_avst_valid = 1'b0;
  endtask

  task automatic check_cnt(input string tag);
    @(negedge clk);
    #4;
    check({tag, "_bad_cnt"}, 64'(bad_cnt), 64'(m_bad));
    check({tag, "_nosop_cnt"}, 64'(nosop_cnt), 64'(m_nosop));
  endtask

  always @(negedge clk) if (rand_rdy) o_ready = NP'($urandom | $urandom);

  // Output monitor: in-order delivery per port, and stalled outputs must hold.
  always begin
    @(negedge clk);
    #4;
    for (int p = 0; p < NP; p++) begin
      logic [PW-1:0] obs;
      obs = {o_sop[p], o_eop[p], o_err[p], o_empty[p], o_data[p], o_user[p]};
      if (!rst_n) begin
        prev_stall[p] = 1'b0;
      end else begin
        if (prev_stall[p]) begin
          check($sformatf("p%0d_stall_valid", p), 64'(o_valid[p]), 64'd1);
          check($sformatf("p%0d_stall_hold", p), 64'(obs), 64'(prev_pay[p]));
        end
        if (o_valid[p] && o_ready[p]) begin
          if (expq[p].size() == 0) check($sformatf("p%0d_extra_beat", p), 64'(expq[p].size()), 64'd1);
          else check($sformatf("p%0d_beat", p), 64'(obs), 64'(expq[p].pop_front()));
        end
        prev_stall[p] = o_valid[p] && !o_ready[p];
        prev_pay[p]   = obs;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    int len;
    logic [CW-1:0] ch;
    logic [CW-1:0] bad_chs [4];
    bad_chs[0] = 4'b0000;
    bad_chs[1] = 4'b0110;
    bad_chs[2] = 4'b1001;
    bad_chs[3] = 4'b1111;
    for (int p = 0; p < NP; p++) prev_stall[p] = 1'b0;

    repeat (3) @(negedge clk);
    #4;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data[2]), 64'd0);
    check("rst_in_ready", 64'(i_avst_ready), 64'd0);
    check("rst_bad_cnt", 64'(bad_cnt), 64'd0);
    check("rst_nosop_cnt", 64'(nosop_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    o_ready = '1;

    // 1: single-beat then 3-beat packet to port 2
    send(1'b1, 1'b1, 4'b0100, f);
    check("t1_latency", 64'(o_valid), 64'b0100);
    send(1'b1, 1'b0, 4'b0100, f);
    send(1'b0, 1'b0, 4'b0100, f);
    send(1'b0, 1'b1, 4'b0100, f);

    // 2: channel changes mid-packet, must stay on port 1
    send(1'b1, 1'b0, 4'b0010, f);
    send(1'b0, 1'b0, 4'b1000, f);
    send(1'b0, 1'b1, 4'b1000, f);

    // 3: two-hot channel, whole packet dropped without backpressure
    send(1'b1, 1'b0, 4'b0110, f);
    check("t3_ready_sop", 64'(f), 64'd1);
    send(1'b0, 1'b1, 4'b0110, f);
    check("t3_ready_eop", 64'(f), 64'd1);
    check_cnt("t3");

    // 4: stray non-SOP beat in IDLE
    send(1'b0, 1'b1, 4'b0001, f);
    check("t4_ready", 64'(f), 64'd1);
    check_cnt("t4");
    check("t4_no_valid", 64'(o_valid), 64'd0);

    // 5: port 0 stalled, input blocks from the third beat
    @(negedge clk);
    o_ready = 4'b1110;
    send(1'b1, 1'b0, 4'b0001, f);
    send(1'b0, 1'b0, 4'b0001, f);
    @(negedge clk);
    i_avst_valid = 1'b1;
    i_sop = 1'b0;
    i_eop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #4;
      check("t5_in_ready_low", 64'(i_avst_ready), 64'd0);
      check("t5_p0_valid", 64'(o_valid[0]), 64'd1);
      if (c < 3) @(negedge clk);
    end
    i_avst_valid = 1'b0;
    @(negedge clk);
    o_ready = '1;
    send(1'b0, 1'b0, 4'b0001, f);
    send(1'b0, 1'b0, 4'b0001, f);
    send(1'b0, 1'b1, 4'b0001, f);

    // random traffic with random downstream backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(9) == 0) send(1'b0, 1'($urandom_range(1)), CW'($urandom), f);
      if ($urandom_range(6) == 0) ch = bad_chs[$urandom_range(3)];
      else ch = 4'b0001 << $urandom_range(3);
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        send((b == 0) ? 1'b1 : 1'($urandom_range(4) == 0), 1'(b == len - 1),
             (b == 0) ? ch : CW'($urandom), f);
      end
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    o_ready = '1;
    repeat (10) @(negedge clk);
    for (int p = 0; p < NP; p++) check($sformatf("rnd_drain_p%0d", p), 64'(expq[p].size()), 64'd0);
    check_cnt("rnd");

    // 6: reset in the middle of a buffered packet
    @(negedge clk);
    o_ready = 4'b1110;
    send(1'b1, 1'b0, 4'b0001, f);
    send(1'b0, 1'b0, 4'b0001, f);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_valid", 64'(o_valid), 64'd0);
    check("t6_rst_bad_cnt", 64'(bad_cnt), 64'd0);
    check("t6_rst_nosop_cnt", 64'(nosop_cnt), 64'd0);
    check("t6_rst_in_ready", 64'(i_avst_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    o_ready = '1;
    send(1'b0, 1'b1, 4'b0001, f);
    check_cnt("t6_tail");
    send(1'b1, 1'b0, 4'b1000, f);
    send(1'b0, 1'b1, 4'b1000, f);
    for (int k = 0; k < SAT + 3; k++) send(1'b0, 1'b0, 4'b0001, f);
    check_cnt("t6_sat");
    send(1'b0, 1'b1, 4'b0010, f);
    check_cnt("t6_sat_hold");
    repeat (5) @(negedge clk);
    for (int p = 0; p < NP; p++) check($sformatf("end_drain_p%0d", p), 64'(expq[p].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
